// File: rtl/bank_ctrl_pkg.sv
// Shared definitions for the bank-group controller: FSM state encoding,
// default timing constants and a small sizing helper.
package bank_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRE    = 3'd1,
      ST_ACT    = 3'd2,
      ST_ACCESS = 3'd3,
      ST_RDWAIT = 3'd4,
      ST_RESP   = 3'd5
   } state_e;

   localparam int DEF_TRCD   = 2;
   localparam int DEF_TRP    = 2;
   localparam int DEF_TRAS   = 4;
   localparam int DEF_RD_LAT = 1;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/bank_tracker.sv
// Per-bank bookkeeping: open flag, recorded open row and the tRAS countdown
// that gates how soon an open row may be precharged.
module bank_tracker
   import bank_ctrl_pkg::*;
#(
   parameter int CHWIDTH = 5,
   parameter int TRAS    = DEF_TRAS
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               act_i,
   input  logic               close_i,
   input  logic [CHWIDTH-1:0] row_i,
   output logic               open_o,
   output logic [CHWIDTH-1:0] row_o,
   output logic               tras_zero_o
);

   localparam int TW = $clog2(TRAS + 1);

   logic               open_q;
   logic [CHWIDTH-1:0] row_q;
   logic [TW-1:0]      tras_q;

   // Activation reloads tRAS; otherwise it free-runs down to zero.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         open_q <= 1'b0;
         row_q  <= '0;
         tras_q <= '0;
      end else begin
         if (act_i) begin
            open_q <= 1'b1;
            row_q  <= row_i;
            tras_q <= TW'(TRAS);
         end else begin
            if (close_i) begin
               open_q <= 1'b0;
               row_q  <= '0;
            end else begin
               open_q <= open_q;
               row_q  <= row_q;
            end
            if (tras_q != '0) begin
               tras_q <= tras_q - TW'(1);
            end else begin
               tras_q <= tras_q;
            end
         end
      end
   end

   assign open_o      = open_q;
   assign row_o       = row_q;
   assign tras_zero_o = (tras_q == '0);

endmodule

// File: rtl/bank_group_ctrl.sv
// Single-request bank-group controller: precharge/activate/access sequencing
// in front of BANKSPERGROUP banks, one outstanding request at a time.
module bank_group_ctrl
   import bank_ctrl_pkg::*;
#(
   parameter int BAWIDTH       = 2,
   parameter int BANKSPERGROUP = 2 ** BAWIDTH,
   parameter int COLWIDTH      = 10,
   parameter int CHWIDTH       = 5,
   parameter int DEVICE_WIDTH  = 4,
   parameter int TRCD          = DEF_TRCD,
   parameter int TRP           = DEF_TRP,
   parameter int TRAS          = DEF_TRAS,
   parameter int RD_LAT        = DEF_RD_LAT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [BAWIDTH-1:0]       req_bank,
   input  logic [CHWIDTH-1:0]       req_row,
   input  logic [COLWIDTH-1:0]      req_col,
   input  logic                     req_wr,
   input  logic [DEVICE_WIDTH-1:0]  req_wdata,
   output logic                     resp_valid,
   output logic [DEVICE_WIDTH-1:0]  resp_rdata,
   output logic                     bg_rd_o_wr [BANKSPERGROUP-1:0],
   output logic [DEVICE_WIDTH-1:0]  bg_dqin    [BANKSPERGROUP-1:0],
   output logic [CHWIDTH-1:0]       bg_row     [BANKSPERGROUP-1:0],
   output logic [COLWIDTH-1:0]      bg_column  [BANKSPERGROUP-1:0],
   input  logic [DEVICE_WIDTH-1:0]  bg_dqout   [BANKSPERGROUP-1:0],
   output logic [BANKSPERGROUP-1:0] bank_open
);

   localparam int CNT_W = $clog2(max3(TRCD, TRP, RD_LAT)) + 1;

   state_e                    state_q;
   logic [CNT_W-1:0]          cnt_q;
   logic [BAWIDTH-1:0]        bank_q;
   logic [CHWIDTH-1:0]        row_q;
   logic [COLWIDTH-1:0]       col_q;
   logic                      wr_q;
   logic [DEVICE_WIDTH-1:0]   wdata_q;
   logic                      req_ready_q;
   logic                      resp_valid_q;
   logic [DEVICE_WIDTH-1:0]   resp_rdata_q;

   logic [BANKSPERGROUP-1:0]  trk_open_s;
   logic [BANKSPERGROUP-1:0]  trk_zero_s;
   logic [CHWIDTH-1:0]        trk_row_s [BANKSPERGROUP-1:0];
   logic                      hit_s;
   logic                      act_go_s;
   logic                      close_go_s;

   // Hit detection looks at the incoming request so the route is known at N+1.
   assign hit_s      = trk_open_s[req_bank] && (trk_row_s[req_bank] == req_row);
   assign act_go_s   = (state_q == ST_ACT) && (cnt_q == CNT_W'(TRCD - 1));
   assign close_go_s = (state_q == ST_PRE) && trk_zero_s[bank_q] &&
                       (cnt_q == CNT_W'(TRP - 1));

   for (genvar g = 0; g < BANKSPERGROUP; g++) begin : g_trk
      bank_tracker #(
         .CHWIDTH (CHWIDTH),
         .TRAS    (TRAS)
      ) u_trk (
         .clk_i       (clk),
         .rst_i       (rst),
         .act_i       (act_go_s && (bank_q == BAWIDTH'(g))),
         .close_i     (close_go_s && (bank_q == BAWIDTH'(g))),
         .row_i       (row_q),
         .open_o      (trk_open_s[g]),
         .row_o       (trk_row_s[g]),
         .tras_zero_o (trk_zero_s[g])
      );
   end

   // Request sequencing FSM; cnt_q times PRE (after tRAS), ACT and RDWAIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         bank_q       <= '0;
         row_q        <= '0;
         col_q        <= '0;
         wr_q         <= 1'b0;
         wdata_q      <= '0;
         req_ready_q  <= 1'b1;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
      end else begin
         resp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req_valid && req_ready_q) begin
                  bank_q      <= req_bank;
                  row_q       <= req_row;
                  col_q       <= req_col;
                  wr_q        <= req_wr;
                  wdata_q     <= req_wdata;
                  cnt_q       <= '0;
                  req_ready_q <= 1'b0;
                  if (hit_s) begin
                     state_q <= ST_ACCESS;
                  end else if (trk_open_s[req_bank]) begin
                     state_q <= ST_PRE;
                  end else begin
                     state_q <= ST_ACT;
                  end
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            ST_PRE: begin
               if (!trk_zero_s[bank_q]) begin
                  cnt_q <= '0;
               end else if (cnt_q == CNT_W'(TRP - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_ACT;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_ACT: begin
               if (cnt_q == CNT_W'(TRCD - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_ACCESS;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_ACCESS: begin
               cnt_q <= '0;
               if (wr_q) begin
                  resp_valid_q <= 1'b1;
                  state_q      <= ST_RESP;
               end else begin
                  state_q <= ST_RDWAIT;
               end
            end
            ST_RDWAIT: begin
               if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                  resp_rdata_q <= bg_dqout[bank_q];
                  resp_valid_q <= 1'b1;
                  cnt_q        <= '0;
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_RESP: begin
               req_ready_q <= 1'b1;
               state_q     <= ST_IDLE;
            end
            default: begin
               req_ready_q <= 1'b1;
               cnt_q       <= '0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   // Bank-port steering: only the target bank ever sees non-idle values.
   always_comb begin
      for (int b = 0; b < BANKSPERGROUP; b++) begin
         bg_rd_o_wr[b] = 1'b0;
         bg_dqin[b]    = '0;
         bg_column[b]  = '0;
         bg_row[b]     = trk_row_s[b];
         if (bank_q == BAWIDTH'(b)) begin
            if (state_q == ST_ACT) begin
               bg_row[b] = row_q;
            end else begin
               bg_row[b] = trk_row_s[b];
            end
            if (state_q == ST_ACCESS) begin
               bg_column[b]  = col_q;
               bg_rd_o_wr[b] = wr_q;
               bg_dqin[b]    = wr_q ? wdata_q : '0;
            end else begin
               bg_column[b]  = '0;
               bg_rd_o_wr[b] = 1'b0;
               bg_dqin[b]    = '0;
            end
         end else begin
            bg_row[b] = trk_row_s[b];
         end
      end
   end

   assign req_ready  = req_ready_q;
   assign resp_valid = resp_valid_q;
   assign resp_rdata = resp_rdata_q;
   assign bank_open  = trk_open_s;

endmodule

// File: tb/tb_bank_group_ctrl.sv
// Directed + randomized bench for bank_group_ctrl; expectations come from a
// cycle-arithmetic model of open rows, tRAS expiry and access latencies.
module tb_bank_group_ctrl;

   localparam int BW = 2, NB = 4, CW = 10, RW = 5, DW = 4;
   localparam int TRCD = 2, TRP = 2, TRAS = 4, RD_LAT = 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic [BW-1:0]  req_bank = '0;
   logic [RW-1:0]  req_row = '0;
   logic [CW-1:0]  req_col = '0;
   logic           req_wr = 1'b0;
   logic [DW-1:0]  req_wdata = '0;
   logic           resp_valid;
   logic [DW-1:0]  resp_rdata;
   logic           bg_rd_o_wr [NB-1:0];
   logic [DW-1:0]  bg_dqin    [NB-1:0];
   logic [RW-1:0]  bg_row     [NB-1:0];
   logic [CW-1:0]  bg_column  [NB-1:0];
   logic [DW-1:0]  bg_dqout   [NB-1:0];
   logic [NB-1:0]  bank_open;

   int cyc = 0;
   int tests = 0;
   int fails = 0;

   bit            open_m  [NB];
   logic [RW-1:0] row_m   [NB];
   int            rzero_m [NB];
   logic [DW-1:0] dq_m    [NB];
   logic [DW-1:0] last_rd_m;

   bank_group_ctrl #(
      .BAWIDTH(BW), .BANKSPERGROUP(NB), .COLWIDTH(CW), .CHWIDTH(RW),
      .DEVICE_WIDTH(DW), .TRCD(TRCD), .TRP(TRP), .TRAS(TRAS), .RD_LAT(RD_LAT)
   ) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
      .req_wr(req_wr), .req_wdata(req_wdata), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .bg_rd_o_wr(bg_rd_o_wr), .bg_dqin(bg_dqin),
      .bg_row(bg_row), .bg_column(bg_column), .bg_dqout(bg_dqout),
      .bank_open(bank_open)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NB; i++) begin
         open_m[i] = 1'b0; row_m[i] = '0; rzero_m[i] = 0;
      end
      last_rd_m = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, req_ready, 1);
      chk({tag, "_resp_valid"}, resp_valid, 0);
      chk({tag, "_resp_rdata"}, resp_rdata, 0);
      chk({tag, "_bank_open"}, bank_open, 0);
      for (int i = 0; i < NB; i++) begin
         chk($sformatf("%s_bg_wr%0d", tag, i), bg_rd_o_wr[i], 0);
         chk($sformatf("%s_bg_dqin%0d", tag, i), bg_dqin[i], 0);
         chk($sformatf("%s_bg_row%0d", tag, i), bg_row[i], 0);
         chk($sformatf("%s_bg_col%0d", tag, i), bg_column[i], 0);
      end
   endtask

   task automatic apply_reset(input string tag);
      @(negedge clk);
      req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check_all_zero(tag);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      chk({tag, "_ready_after"}, req_ready, 1);
   endtask

   // Issue one request from an IDLE negedge and check every cycle until ready again.
   task automatic do_req(input int b, input logic [RW-1:0] row, input logic [CW-1:0] col,
                         input logic wr, input logic [DW-1:0] wd, input int force_dq);
      int n, t, act_s, acc_s, resp_s, kr;
      bit hit, was_open, acc_now, e_open, e_wr;
      logic [RW-1:0] old_row, e_row;
      logic [CW-1:0] e_col;
      logic [DW-1:0] e_dq;
      chk("ready_before_req", req_ready, 1);
      n = cyc;
      was_open = open_m[b];
      old_row  = row_m[b];
      hit = was_open && (old_row == row);
      if (hit) begin
         act_s = -1; acc_s = n + 1;
      end else if (!was_open) begin
         act_s = n + 1; acc_s = act_s + TRCD;
      end else begin
         act_s = ((n + 1 > rzero_m[b]) ? n + 1 : rzero_m[b]) + TRP;
         acc_s = act_s + TRCD;
      end
      resp_s = acc_s + 1 + (wr ? 0 : RD_LAT);
      kr = resp_s - n;
      for (int i = 0; i < NB; i++) begin
         dq_m[i] = DW'($urandom_range(0, 15));
         bg_dqout[i] = dq_m[i];
      end
      if (force_dq >= 0) begin
         dq_m[b] = DW'(force_dq);
         bg_dqout[b] = dq_m[b];
      end
      req_valid = 1'b1; req_bank = BW'(b); req_row = row; req_col = col;
      req_wr = wr; req_wdata = wd;
      @(posedge clk);
      #1;
      for (int k = 1; k <= kr + 1; k++) begin
         // garbage requests while busy must be ignored
         req_valid = 1'($urandom_range(0, 1));
         req_bank = BW'($urandom_range(0, NB - 1)); req_row = RW'($urandom);
         req_col = CW'($urandom); req_wr = 1'($urandom); req_wdata = DW'($urandom);
         @(negedge clk);
         t = n + k;
         chk("resp_valid", resp_valid, (k == kr));
         chk("req_ready", req_ready, (k == kr + 1));
         if (k >= kr && !wr) chk("resp_rdata", resp_rdata, dq_m[b]);
         else chk("resp_rdata_hold", resp_rdata, last_rd_m);
         for (int i = 0; i < NB; i++) begin
            if (i == b) begin
               acc_now = (t == acc_s);
               if (act_s >= 0 && t >= act_s) e_row = row;
               else if (was_open) e_row = old_row;
               else e_row = '0;
               if (hit || t >= acc_s) e_open = 1'b1;
               else if (was_open && t < act_s) e_open = 1'b1;
               else e_open = 1'b0;
               e_col = acc_now ? col : '0;
               e_wr  = acc_now && wr;
               e_dq  = (acc_now && wr) ? wd : '0;
            end else begin
               e_row = open_m[i] ? row_m[i] : '0;
               e_open = open_m[i]; e_col = '0; e_wr = 1'b0; e_dq = '0;
            end
            chk($sformatf("bg_row[%0d]", i), bg_row[i], e_row);
            chk($sformatf("bg_column[%0d]", i), bg_column[i], e_col);
            chk($sformatf("bg_rd_o_wr[%0d]", i), bg_rd_o_wr[i], e_wr);
            chk($sformatf("bg_dqin[%0d]", i), bg_dqin[i], e_dq);
            chk($sformatf("bank_open[%0d]", i), bank_open[i], e_open);
         end
      end
      if (!hit) rzero_m[b] = acc_s + TRAS;
      open_m[b] = 1'b1;
      row_m[b] = row;
      if (!wr) last_rd_m = dq_m[b];
   endtask

   // Three row-hit reads with req_valid held high throughout.
   task automatic b2b();
      int bq [3];
      int acc_c [3];
      int idx, nresp;
      bq[0] = 1; bq[1] = 3; bq[2] = 0;
      idx = 0; nresp = 0;
      for (int i = 0; i < NB; i++) begin
         dq_m[i] = DW'($urandom_range(0, 15));
         bg_dqout[i] = dq_m[i];
      end
      req_valid = 1'b1; req_bank = BW'(bq[0]); req_row = row_m[bq[0]];
      req_col = CW'($urandom); req_wr = 1'b0;
      for (int s = 0; s < 60 && (idx < 3 || nresp < 3); s++) begin
         if (s > 0) @(negedge clk);
         if (resp_valid) begin
            if (nresp < 3) chk("b2b_rdata", resp_rdata, dq_m[bq[nresp]]);
            nresp++;
         end
         if (req_ready && req_valid && idx < 3) begin
            acc_c[idx] = cyc;
            idx++;
            @(posedge clk);
            #1;
            if (idx < 3) begin
               req_bank = BW'(bq[idx]); req_row = row_m[bq[idx]]; req_col = CW'($urandom);
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      chk("b2b_accepts", idx, 3);
      chk("b2b_resps", nresp, 3);
      if (idx == 3) begin
         chk("b2b_gap01", acc_c[1] - acc_c[0], 2 + RD_LAT + 1);
         chk("b2b_gap12", acc_c[2] - acc_c[1], 2 + RD_LAT + 1);
      end
      @(negedge clk);
      chk("b2b_ready_end", req_ready, 1);
      last_rd_m = dq_m[bq[2]];
   endtask

   initial begin
      int sel, b;
      logic [RW-1:0] r;
      logic [CW-1:0] c;
      for (int i = 0; i < NB; i++) bg_dqout[i] = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // reset while the controller is activating bank 2
      req_valid = 1'b1; req_bank = 2'd2; req_row = 5'd1; req_col = 10'd4;
      req_wr = 1'b1; req_wdata = 4'h5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("midop_act_row", bg_row[2], 5'd1);
      rst = 1'b1;
      @(negedge clk);
      check_all_zero("midop");
      rst = 1'b0;
      model_reset();
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("midop_no_resp", resp_valid, 0);
         chk("midop_ready", req_ready, 1);
         chk("midop_open", bank_open, 0);
      end

      // cold write, miss during tRAS, reopen, then row-hit read
      do_req(1, 5'd3, 10'd5, 1'b1, 4'hA, -1);
      chk("cold_bank_open", bank_open, 4'b0010);
      do_req(1, 5'd7, 10'd5, 1'b0, 4'h0, -1);
      chk("miss_row7", bg_row[1], 5'd7);
      do_req(1, 5'd3, 10'd5, 1'b1, 4'hA, -1);
      do_req(1, 5'd3, 10'd5, 1'b0, 4'h0, 10);

      // bank independence
      do_req(0, 5'd2, 10'd0, 1'b1, 4'h3, -1);
      do_req(3, 5'd9, 10'd1, 1'b1, 4'hC, -1);
      do_req(3, 5'd9, 10'd1023, 1'b0, 4'h0, -1);
      do_req(3, 5'd9, 10'd1023, 1'b1, 4'hF, -1);
      chk("indep_row0", bg_row[0], 5'd2);
      chk("indep_row3", bg_row[3], 5'd9);

      b2b();

      for (int n = 0; n < 40; n++) begin
         b = $urandom_range(0, NB - 1);
         sel = $urandom_range(0, 3);
         case (sel)
            0: r = '0;
            1: r = '1;
            2: r = row_m[b];
            default: r = RW'($urandom);
         endcase
         sel = $urandom_range(0, 2);
         c = (sel == 0) ? '0 : (sel == 1) ? '1 : CW'($urandom);
         do_req(b, r, c, 1'($urandom), DW'($urandom), -1);
      end

      apply_reset("final");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
